// File: rtl/ifetch_ir_pkg.sv
// Shared definitions for the instruction-fetch / IR stage: opcodes, FSM states, offset width.
package ifetch_ir_pkg;

  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam int         OFFSET_W = 18;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/ifetch_decode.sv
// Combinational jump/branch field extraction from the instruction register.
module ifetch_decode
  import ifetch_ir_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   ir,
  input  logic                ir_valid,
  output logic                j_en,
  output logic                bgtz_en,
  output logic [OFFSET_W-1:0] offset
);

  logic [5:0] opcode;
  logic       unused_ir_bits;

  assign opcode         = ir[DATA_W-1 -: 6];
  assign unused_ir_bits = ^ir[DATA_W-7:16];

  // Enables are qualified so a stale or reset IR never redirects the PC.
  assign j_en    = ir_valid && (opcode == OP_J);
  assign bgtz_en = ir_valid && (opcode == OP_BGTZ);
  assign offset  = {ir[15:0], 2'b00};

endmodule

// File: rtl/ifetch_ir.sv
// Instruction fetch / IR stage: req/ack memory read, IR hold until consumed, jump/branch decode.
// Optional memory timeout with sticky error flag when IFETCH_TIMEOUT_EN is defined.
module ifetch_ir
  import ifetch_ir_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] RESET_IR       = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   pc,
  input  logic                fetch_start,
  input  logic                flush,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [DATA_W-1:0]   imem_rdata,
  output logic [DATA_W-1:0]   ir,
  output logic                ir_valid,
  input  logic                ir_ready,
  output logic                j_en,
  output logic                bgtz_en,
  output logic [OFFSET_W-1:0] offset,
  output logic                fetch_busy,
  output logic                fetch_err
);

  fetch_state_t state, state_nxt;
  logic         timeout_fire;
  logic         unused_pc_bits;

  assign unused_pc_bits = ^pc[1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (fetch_start && !flush) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (imem_ack)          state_nxt = flush ? S_IDLE : S_HOLD;
        else if (flush)        state_nxt = S_DROP;
        else if (timeout_fire) state_nxt = S_IDLE;
      end
      S_HOLD: begin
        if (flush || ir_ready) state_nxt = S_IDLE;
      end
      S_DROP: begin
        if (imem_ack || timeout_fire) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The bus transaction stays open through DROP so memory is never left with a dangling request.
  always_comb begin
    imem_req   = (state == S_REQ) || (state == S_DROP);
    ir_valid   = (state == S_HOLD);
    fetch_busy = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_addr <= '0;
      ir        <= RESET_IR;
    end else begin
      if (state == S_IDLE && state_nxt == S_REQ) imem_addr <= {pc[ADDR_W-1:2], 2'b00};
      if (state == S_REQ && imem_ack && !flush)  ir <= imem_rdata;
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             waiting;

  assign waiting = (state == S_REQ) || (state == S_DROP);
  // A flush in REQ takes priority: it restarts the wait in DROP instead of timing out.
  assign timeout_fire = waiting && !imem_ack && !(state == S_REQ && flush)
                        && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt    <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state_nxt != state && (state_nxt == S_REQ || state_nxt == S_DROP)) to_cnt <= '0;
      else if (waiting && !imem_ack)                                            to_cnt <= to_cnt + 1'b1;
      if (timeout_fire) fetch_err <= 1'b1;
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign fetch_err    = 1'b0;
`endif

  ifetch_decode #(.DATA_W(DATA_W)) u_decode (
    .ir       (ir),
    .ir_valid (ir_valid),
    .j_en     (j_en),
    .bgtz_en  (bgtz_en),
    .offset   (offset)
  );

endmodule

// File: tb/tb_ifetch_ir.sv
// Self-checking bench for ifetch_ir: transaction-level model plus directed scenarios.
module tb_ifetch_ir;

`ifdef IFETCH_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        fetch_start = 1'b0;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        j_en;
  logic        bgtz_en;
  logic [17:0] offset;
  logic        fetch_busy;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;
  int req_rises = 0;

  ifetch_ir #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .RESET_IR(32'h0)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_start(fetch_start), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready), .j_en(j_en), .bgtz_en(bgtz_en),
    .offset(offset), .fetch_busy(fetch_busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction view: an open bus request, a held instruction, or nothing.
  logic        m_req = 1'b0, m_drop = 1'b0, m_valid = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_ir = '0;
  int          m_wait = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_req = 0; m_drop = 0; m_valid = 0; m_err = 0; m_addr = '0; m_ir = '0; m_wait = 0;
    end else if (m_req) begin
      if (imem_ack) begin
        if (!m_drop && !flush) begin
          m_ir = imem_rdata;
          m_valid = 1;
        end
        m_req = 0; m_drop = 0;
      end else if (flush && !m_drop) begin
        m_drop = 1; m_wait = 0;
      end else begin
        m_wait++;
`ifdef IFETCH_TIMEOUT_EN
        if (m_wait == TO) begin
          m_req = 0; m_drop = 0; m_err = 1;
        end
`endif
      end
    end else if (m_valid) begin
      if (flush || ir_ready) m_valid = 0;
    end else if (fetch_start && !flush) begin
      m_addr = pc & 32'hFFFF_FFFC;
      m_req = 1; m_wait = 0;
    end
  end

  logic prev_req = 1'b0;
  always @(negedge clk) begin
    check("req", imem_req, m_req);
    check("addr", imem_addr, m_addr);
    check("ir", ir, m_ir);
    check("ir_valid", ir_valid, m_valid);
    check("j_en", j_en, m_valid && m_ir[31:26] == 6'd2);
    check("bgtz_en", bgtz_en, m_valid && m_ir[31:26] == 6'd7);
    check("offset", offset, {m_ir[15:0], 2'b00});
    check("busy", fetch_busy, m_req || m_valid);
    check("err", fetch_err, m_err);
    if (imem_req === 1'b1 && prev_req !== 1'b1) req_rises++;
    prev_req = imem_req;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] a);
    pc = a; fetch_start = 1; tick(); fetch_start = 0;
  endtask

  task automatic ack_with(input logic [31:0] d);
    imem_ack = 1; imem_rdata = d; tick(); imem_ack = 0;
  endtask

  int rises0;
  int hi;

  initial begin
    tick(2);
    rst = 0;
    tick();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_ir", ir, 32'h0);
    check("rst_valid", ir_valid, 0);
    check("rst_busy", fetch_busy, 0);

    // Basic BGTZ fetch, ack three cycles after the strobe
    strobe(32'h40);
    check("basic_req", imem_req, 1);
    check("basic_addr", imem_addr, 32'h40);
    tick(2);
    ack_with(32'h1C00_0005);
    check("basic_valid", ir_valid, 1);
    check("basic_ir", ir, 32'h1C00_0005);
    check("basic_bgtz", bgtz_en, 1);
    check("basic_j", j_en, 0);
    check("basic_off", offset, 18'h14);
    ir_ready = 1; tick(); ir_ready = 0;
    check("basic_consumed", ir_valid, 0);
    check("basic_idle", fetch_busy, 0);
    check("basic_ir_kept", ir, 32'h1C00_0005);

    // Jump with back-to-back ack and a stalled consumer
    strobe(32'h100);
    ack_with(32'h0800_0010);
    for (int i = 0; i < 5; i++) begin
      check("jump_hold_valid", ir_valid, 1);
      check("jump_hold_j", j_en, 1);
      tick();
    end
    check("jump_off", offset, 18'h40);
    ir_ready = 1; tick(); ir_ready = 0;
    check("jump_idle", fetch_busy, 0);
    check("jump_j_off", j_en, 0);

    // Flush during REQ: data discarded, bus still completes
    strobe(32'h80);
    tick();
    flush = 1; tick(); flush = 0;
    check("drop_busy", fetch_busy, 1);
    check("drop_req", imem_req, 1);
    tick();
    ack_with(32'hFFFF_FFFF);
    check("drop_ir", ir, 32'h0800_0010);
    check("drop_valid", ir_valid, 0);
    check("drop_idle", fetch_busy, 0);

    // Strobes during REQ and HOLD ignored; unaligned pc
    rises0 = req_rises;
    strobe(32'h43);
    check("unal_addr", imem_addr, 32'h40);
    strobe(32'h200);
    check("ign_addr", imem_addr, 32'h40);
    ack_with(32'h1C00_FFFF);
    check("neg_off", offset, 18'h3FFFC);
    strobe(32'h300);
    check("ign_hold_valid", ir_valid, 1);
    check("ign_hold_req", imem_req, 0);
    ir_ready = 1; tick(); ir_ready = 0;
    tick(3);
    check("one_txn", req_rises - rises0, 1);

    // Flush together with ir_ready in HOLD, then flush with strobe in IDLE
    strobe(32'h44);
    ack_with(32'h0800_0003);
    flush = 1; ir_ready = 1; tick(); flush = 0; ir_ready = 0;
    check("fhold_valid", ir_valid, 0);
    check("fhold_ir", ir, 32'h0800_0003);
    flush = 1; strobe(32'h48); flush = 0;
    check("fidle_req", imem_req, 0);
    check("fidle_busy", fetch_busy, 0);

    // Reset mid-REQ, late ack ignored
    strobe(32'h50);
    check("mid_req", imem_req, 1);
    rst = 1; tick(); rst = 0;
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_ir", ir, 32'h0);
    ack_with(32'h0800_0001);
    check("late_ack_ir", ir, 32'h0);
    check("late_ack_valid", ir_valid, 0);

    // Memory that never answers
    strobe(32'h60);
`ifdef IFETCH_TIMEOUT_EN
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) hi++;
      tick();
    end
    check("to_req_cycles", hi, TO);
    check("to_err", fetch_err, 1);
    check("to_busy", fetch_busy, 0);
    rst = 1; tick(); rst = 0;
    check("to_err_clr", fetch_err, 0);
`else
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      if (imem_req === 1'b1) hi++;
      tick();
    end
    check("noto_req_cycles", hi, 300);
    check("noto_err", fetch_err, 0);
    ack_with(32'h1C00_0001);
    check("noto_valid", ir_valid, 1);
    ir_ready = 1; tick(); ir_ready = 0;
`endif
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
